// File: rtl/fetch_stage_pkg.sv
// Shared constants and state type for the instruction-fetch front end.
package fetch_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [XLEN-1:0]   RESET_PC_DEF = 32'h4000_0000;
  localparam logic [INST_W-1:0] NOP_INST_DEF = 32'h0000_0013;

  // Encoding is {req_v, hold_v}; 2'b11 is never reached.
  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    STREAM = 2'b10,
    HOLD   = 2'b01
  } fetchState_t;

endpackage

// File: rtl/fetch_stage_hold_buf.sv
// Tracks whether decode holds a live instruction and keeps it stable across stalls.
module fetch_hold_buf
  import fetch_stage_pkg::*;
#(
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic              redirectValid,
  input  logic [INST_W-1:0] imemRdata,
  output logic              busy,
  output logic              validD,
  output logic [INST_W-1:0] instD
);

  fetchState_t state, stateNext;
  logic [INST_W-1:0] holdInst;
  logic reqV, holdV;

  assign reqV = state[1];
  assign holdV = state[0];

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (issue)                 stateNext = STREAM;
    else if (state == STREAM)  stateNext = HOLD;
  end

  // Memory data is only valid the cycle after a request, so capture it on the first stalled cycle.
  always_ff @(posedge clk) begin
    if (rst)                            holdInst <= NOP_INST;
    else if (!issue && state == STREAM) holdInst <= imemRdata;
  end

  assign busy   = reqV | holdV;
  assign validD = busy & ~redirectValid;

  always_comb begin
    instD = imemRdata;
    if (!validD)    instD = NOP_INST;
    else if (holdV) instD = holdInst;
  end

  stateLegal: assert property (@(posedge clk) disable iff (rst) !(reqV && holdV));

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: PC register, next-address selection and delivered-instruction counter.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0]   RESET_PC = RESET_PC_DEF,
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_f,
  input  logic              stall_d,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_en,
  output logic [XLEN-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst_d,
  output logic [XLEN-1:0]   pc_d,
  output logic              valid_d,
  output logic [31:0]       fetch_count
);

  logic [XLEN-1:0] pcF, nextAddr;
  logic issue, busy;
  logic [1:0] unusedRedirectLsbs;

  assign unusedRedirectLsbs = redirect_pc[1:0];
  assign issue = redirect_valid | ~stall_f;

  // EMPTY has no instruction in flight yet, so it re-issues pcF rather than advancing.
  always_comb begin
    nextAddr = pcF;
    if (redirect_valid) nextAddr = {redirect_pc[XLEN-1:2], 2'b00};
    else if (busy)      nextAddr = pcF + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst)        pcF <= RESET_PC;
    else if (issue) pcF <= nextAddr;
  end

  always_ff @(posedge clk) begin
    if (rst)                       fetch_count <= '0;
    else if (valid_d && !stall_d)  fetch_count <= fetch_count + 32'd1;
  end

  fetch_hold_buf #(.NOP_INST(NOP_INST)) holdBuf (
    .clk           (clk),
    .rst           (rst),
    .issue         (issue),
    .redirectValid (redirect_valid),
    .imemRdata     (imem_rdata),
    .busy          (busy),
    .validD        (valid_d),
    .instD         (inst_d)
  );

  assign imem_en   = issue;
  assign imem_addr = nextAddr;
  assign pc_d      = pcF;

  stallOrder: assert property (@(posedge clk) disable iff (rst) !(stall_d && !stall_f));

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised and directed bench for fetch_stage against a PC-level reference model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall_f, stall_d, redirect_valid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_en, valid_d;
  logic [31:0] imem_addr, inst_d, pc_d, fetch_count;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h4000_0000), .NOP_INST(32'h0000_0013)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .inst_d         (inst_d),
    .pc_d           (pc_d),
    .valid_d        (valid_d),
    .fetch_count    (fetch_count)
  );

  // Memory returns the address as data; unrequested cycles return garbage.
  always @(posedge clk) imem_rdata <= imem_en ? imem_addr : 32'hDEADBEEF;

  // Model: PC of the instruction in decode, whether anything was fetched yet, delivered count.
  logic [31:0] mPc, mCount;
  bit          mStarted, mKnown;
  int          nChecks = 0;
  int          nPass = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step(input bit r, input bit sf, input bit sd, input bit rv, input logic [31:0] rpc);
    bit          expValid, expEn;
    logic [31:0] expAddr;
    rst = r;
    stall_d = sd;
    stall_f = sf | sd;
    redirect_valid = rv;
    redirect_pc = rpc;
    @(negedge clk);
    expEn    = rv | ~(sf | sd);
    expValid = mStarted & ~rv;
    if (rv)            expAddr = {rpc[31:2], 2'b00};
    else if (mStarted) expAddr = mPc + 32'd4;
    else               expAddr = mPc;
    if (mKnown) begin
      checkVal("imem_en", {31'd0, imem_en}, {31'd0, expEn});
      checkVal("imem_addr", imem_addr, expAddr);
      checkVal("valid_d", {31'd0, valid_d}, {31'd0, expValid});
      checkVal("inst_d", inst_d, expValid ? mPc : 32'h0000_0013);
      checkVal("pc_d", pc_d, mPc);
      checkVal("fetch_count", fetch_count, mCount);
    end
    if (r) begin
      mPc = 32'h4000_0000;
      mStarted = 0;
      mCount = '0;
      mKnown = 1;
    end else if (mKnown) begin
      if (expValid && !sd) mCount = mCount + 32'd1;
      if (expEn) begin
        mPc = expAddr;
        mStarted = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          r, sf, sd, rv;
    logic [31:0] rpc;
    mKnown = 0;
    mStarted = 0;
    mPc = '0;
    mCount = '0;
    rst = 1; stall_f = 0; stall_d = 0; redirect_valid = 0; redirect_pc = '0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    // Streaming from reset, then a 3-cycle stall in STREAM
    for (int unsigned i = 0; i < 3; i++) step(0, 0, 0, 0, '0);
    for (int unsigned i = 0; i < 3; i++) step(0, 1, 1, 0, '0);
    for (int unsigned i = 0; i < 3; i++) step(0, 0, 0, 0, '0);
    // Redirect with unaligned target, alone and while stalled
    step(0, 0, 0, 1, 32'h4000_0103);
    for (int unsigned i = 0; i < 2; i++) step(0, 0, 0, 0, '0);
    step(0, 1, 1, 1, 32'h4000_0103);
    for (int unsigned i = 0; i < 2; i++) step(0, 0, 0, 0, '0);
    // Redirect into a redirect, then from HOLD
    step(0, 0, 0, 1, 32'h4000_0200);
    step(0, 0, 0, 1, 32'h4000_0300);
    step(0, 1, 1, 0, '0);
    step(0, 1, 1, 0, '0);
    step(0, 1, 1, 1, 32'h4000_0400);
    step(0, 0, 0, 0, '0);
    // Address wrap past 0xFFFFFFFC
    step(0, 0, 0, 1, 32'hFFFF_FFFC);
    for (int unsigned i = 0; i < 3; i++) step(0, 0, 0, 0, '0);
    // Decode consumes while fetch is frozen
    step(0, 1, 0, 0, '0);
    step(0, 1, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    // Reset while in HOLD, then a 12-cycle run with 2 stall cycles
    step(0, 1, 1, 0, '0);
    step(0, 1, 1, 0, '0);
    step(1, 1, 1, 0, '0);
    for (int unsigned i = 0; i < 12; i++) step(0, (i == 4 || i == 7), (i == 4 || i == 7), 0, '0);
    step(0, 1, 1, 0, '0);
    step(1, 0, 0, 1, 32'h4000_0800);
    step(0, 1, 1, 0, '0);
    step(0, 0, 0, 0, '0);
    // Random traffic
    for (int unsigned i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 59) == 0);
      rv = ($urandom_range(0, 5) == 0);
      sf = ($urandom_range(0, 2) == 0);
      sd = sf && ($urandom_range(0, 1) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(r, sf, sd, rv, rpc);
    end
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
